// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU operation codes, ALUOp classes, FSM state type and decode function
package alu_ctrl_pkg;

    // Operacioni codes driven to the ALU
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_ADDI = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SLR  = 4'b0111;
    localparam logic [3:0] ALU_SLTI = 4'b1001;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_SUBI = 4'b1101;
    localparam logic [3:0] ALU_MUL  = 4'b1110;
    localparam logic [3:0] ALU_DIV  = 4'b1111;

    // Main-control ALU classes
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic       illegal;
    } decode_t;

    // Unlisted encodings fall through to the default: code 0000, illegal set.
    function automatic decode_t alu_decode(input logic [1:0] aluop,
                                           input logic [3:0] opcode,
                                           input logic [1:0] funct);
        decode_t d;
        d.op      = ALU_AND;
        d.illegal = 1'b1;
        case (aluop)
            ALUOP_MEM: begin d.op = ALU_ADD; d.illegal = 1'b0; end
            ALUOP_BR:  begin d.op = ALU_SUB; d.illegal = 1'b0; end
            ALUOP_R: begin
                case ({opcode, funct})
                    6'b0000_00: begin d.op = ALU_AND; d.illegal = 1'b0; end
                    6'b0000_01: begin d.op = ALU_OR;  d.illegal = 1'b0; end
                    6'b0000_10: begin d.op = ALU_XOR; d.illegal = 1'b0; end
                    6'b0001_00: begin d.op = ALU_ADD; d.illegal = 1'b0; end
                    6'b0001_01: begin d.op = ALU_SUB; d.illegal = 1'b0; end
                    6'b0010_00: begin d.op = ALU_SLL; d.illegal = 1'b0; end
                    6'b0010_01: begin d.op = ALU_SLR; d.illegal = 1'b0; end
                    6'b0011_00: begin d.op = ALU_MUL; d.illegal = 1'b0; end
                    6'b0011_01: begin d.op = ALU_DIV; d.illegal = 1'b0; end
                    default:    begin d.op = ALU_AND; d.illegal = 1'b1; end
                endcase
            end
            default: begin
                case (opcode)
                    4'b1001: begin d.op = ALU_ADDI; d.illegal = 1'b0; end
                    4'b1010: begin d.op = ALU_SUBI; d.illegal = 1'b0; end
                    4'b1011: begin d.op = ALU_SLTI; d.illegal = 1'b0; end
                    default: begin d.op = ALU_AND;  d.illegal = 1'b1; end
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// rtl/alu_muldiv_iter.sv - iterative unsigned shift-add multiplier / restoring divider datapath
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_load          : capture operands and clear the counter
//   i_is_div        : operation selected at load (1 = divide, 0 = multiply)
//   i_step          : perform one iteration
//   i_a, i_b        : operands (multiplier/dividend, multiplicand/divisor)
//   o_next_lo/hi    : working value after the current iteration
//   o_last          : counter is at its final iteration (WIDTH-1)
module alu_muldiv_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_is_div,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_next_lo,
    output logic [WIDTH-1:0] o_next_hi,
    output logic             o_last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    // Multiply: {hi,lo} holds partial product above the remaining multiplier bits.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide: {hi,lo} holds remainder above the unconsumed dividend / growing quotient.
    // The remainder is always below the divisor, so the low WIDTH bits of the
    // difference are exact whenever the trial subtraction succeeds.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_b});
    assign w_diff  = w_shift[WIDTH-1:0] - r_b;

    always_comb begin
        o_next_lo = '0;
        o_next_hi = '0;
        if (r_is_div) begin
            o_next_hi = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_next_lo = {r_lo[WIDTH-2:0], w_ge};
        end else begin
            o_next_hi = w_sum[WIDTH:1];
            o_next_lo = {w_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lo     <= '0;
            r_hi     <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_lo     <= i_a;
            r_hi     <= '0;
            r_b      <= i_b;
            r_is_div <= i_is_div;
            r_cnt    <= '0;
        end else if (i_step) begin
            r_lo <= o_next_lo;
            r_hi <= o_next_hi;
            // Counter saturates at WIDTH-1; the FSM leaves on that count.
            if (!o_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - ALU control decode plus sequencing of iterative MUL/DIV
//
// Ports:
//   Clock, Reset              : clock, synchronous active-high reset
//   Start                     : accept the presented instruction (IDLE only)
//   OPCODE, ALUOp, FUNCT      : instruction fields for decode
//   OperandA, OperandB        : unsigned source operands
//   Operacioni                : registered ALU operation code
//   MultiCycle                : accepted instruction is MUL or DIV
//   Busy                      : iterative operation in progress
//   Done                      : one-cycle completion pulse
//   Illegal                   : accepted encoding not in the decode table
//   DivZero                   : DIV accepted with OperandB == 0
//   ResultLo, ResultHi        : product low/high, or quotient/remainder
module alu_exec_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       OPCODE,
    input  logic [1:0]       ALUOp,
    input  logic [1:0]       FUNCT,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic [3:0]       Operacioni,
    output logic             MultiCycle,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal,
    output logic             DivZero,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [3:0]       r_op;
    logic             r_illegal;
    logic             r_multi;
    logic             r_divzero;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;

    decode_t          w_dec;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_is_div;
    logic             w_b_zero;
    logic             w_load;
    logic             w_busy;
    logic             w_last;
    logic [WIDTH-1:0] w_next_lo;
    logic [WIDTH-1:0] w_next_hi;

    assign w_dec    = alu_decode(ALUOp, OPCODE, FUNCT);
    assign w_is_mul = !w_dec.illegal && (w_dec.op == ALU_MUL);
    assign w_is_div = !w_dec.illegal && (w_dec.op == ALU_DIV);
    assign w_b_zero = (OperandB == '0);
    assign w_accept = (r_state == IDLE) && Start;
    // Divide-by-zero completes without touching the iterative datapath.
    assign w_load   = w_accept && (w_is_mul || (w_is_div && !w_b_zero));
    assign w_busy   = (r_state == MUL) || (r_state == DIV);

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (Clock),
        .reset     (Reset),
        .i_load    (w_load),
        .i_is_div  (w_is_div),
        .i_step    (w_busy),
        .i_a       (OperandA),
        .i_b       (OperandB),
        .o_next_lo (w_next_lo),
        .o_next_hi (w_next_hi),
        .o_last    (w_last)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        Busy        = 1'b0;
        Done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    if (w_is_mul) begin
                        w_state_nxt = MUL;
                    end else if (w_is_div && !w_b_zero) begin
                        w_state_nxt = DIV;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            MUL, DIV: begin
                Busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                Done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_op      <= ALU_AND;
            r_illegal <= 1'b0;
            r_multi   <= 1'b0;
            r_divzero <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
        end else if (w_accept) begin
            r_op      <= w_dec.op;
            r_illegal <= w_dec.illegal;
            r_multi   <= w_is_mul || w_is_div;
            r_divzero <= w_is_div && w_b_zero;
            if (w_is_div && w_b_zero) begin
                r_lo <= '1;
                r_hi <= OperandA;
            end
        end else if (w_busy && w_last) begin
            r_lo <= w_next_lo;
            r_hi <= w_next_hi;
        end
    end

    assign Operacioni = r_op;
    assign Illegal    = r_illegal;
    assign MultiCycle = r_multi;
    assign DivZero    = r_divzero;
    assign ResultLo   = r_lo;
    assign ResultHi   = r_hi;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - self-checking scoreboard bench for alu_exec_ctrl
module tb_alu_exec_ctrl;

    localparam int W = 16;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [3:0]   OPCODE = '0;
    logic [1:0]   ALUOp = '0;
    logic [1:0]   FUNCT = '0;
    logic [W-1:0] OperandA = '0;
    logic [W-1:0] OperandB = '0;
    logic [3:0]   Operacioni;
    logic         MultiCycle, Busy, Done, Illegal, DivZero;
    logic [W-1:0] ResultLo, ResultHi;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]   op;
        logic         ill;
        logic         mc;
        logic         dz;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           busy;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic         ill;
        logic         mc;
        logic         dz;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        int           busy;
        bit           done;
    } obs_t;

    exp_t sb_q[$];
    logic [W-1:0] last_lo = '0;
    logic [W-1:0] last_hi = '0;

    alu_exec_ctrl #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .OPCODE(OPCODE), .ALUOp(ALUOp),
        .FUNCT(FUNCT), .OperandA(OperandA), .OperandB(OperandB), .Operacioni(Operacioni),
        .MultiCycle(MultiCycle), .Busy(Busy), .Done(Done), .Illegal(Illegal),
        .DivZero(DivZero), .ResultLo(ResultLo), .ResultHi(ResultHi)
    );

    always #5 Clock = ~Clock;

    // Reference model: decode table plus arithmetic; results hold for non-MUL/DIV.
    task automatic push_expected(input logic [1:0] aop, input logic [3:0] opc,
                                 input logic [1:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] prod;
        e.ill = 1'b0; e.dz = 1'b0; e.busy = 0; e.op = 4'b0000;
        casez ({aop, opc, fn})
            8'b00_????_??: e.op = 4'b0100;
            8'b01_????_??: e.op = 4'b1100;
            8'b10_0000_00: e.op = 4'b0000;
            8'b10_0000_01: e.op = 4'b0010;
            8'b10_0000_10: e.op = 4'b0011;
            8'b10_0001_00: e.op = 4'b0100;
            8'b10_0001_01: e.op = 4'b1100;
            8'b10_0010_00: e.op = 4'b0110;
            8'b10_0010_01: e.op = 4'b0111;
            8'b10_0011_00: e.op = 4'b1110;
            8'b10_0011_01: e.op = 4'b1111;
            8'b11_1001_??: e.op = 4'b0101;
            8'b11_1010_??: e.op = 4'b1101;
            8'b11_1011_??: e.op = 4'b1001;
            default: begin e.op = 4'b0000; e.ill = 1'b1; end
        endcase
        e.mc = !e.ill && (e.op == 4'b1110 || e.op == 4'b1111);
        if (!e.ill && e.op == 4'b1110) begin
            prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            last_lo = prod[W-1:0];
            last_hi = prod[2*W-1:W];
            e.busy = W;
        end else if (!e.ill && e.op == 4'b1111) begin
            if (b == '0) begin
                last_lo = '1; last_hi = a; e.dz = 1'b1;
            end else begin
                last_lo = a / b; last_hi = a % b; e.busy = W;
            end
        end
        e.lo = last_lo;
        e.hi = last_hi;
        sb_q.push_back(e);
    endtask

    // Drives one instruction with a single-cycle Start and waits (bounded) for Done.
    task automatic issue(input logic [1:0] aop, input logic [3:0] opc, input logic [1:0] fn,
                         input logic [W-1:0] a, input logic [W-1:0] b, output obs_t o);
        ALUOp = aop; OPCODE = opc; FUNCT = fn; OperandA = a; OperandB = b;
        push_expected(aop, opc, fn, a, b);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        o.busy = 0; o.done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (Done) begin o.done = 1'b1; break; end
            if (Busy) o.busy++;
            @(posedge Clock); #1;
        end
        o.op = Operacioni; o.ill = Illegal; o.mc = MultiCycle; o.dz = DivZero;
        o.lo = ResultLo; o.hi = ResultHi;
        @(posedge Clock); #1;
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b1; ALUOp = 2'b10; OPCODE = 4'b0011; FUNCT = 2'b00;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        n_total++;
        if ({Operacioni, MultiCycle, Busy, Done, Illegal, DivZero} !== 9'b0) begin
            $display("FAIL reset_flags got %b required 0", {Operacioni, MultiCycle, Busy, Done, Illegal, DivZero});
        end else n_pass++;
        n_total++;
        if ({ResultHi, ResultLo} !== '0) $display("FAIL reset_results got %h required 0", {ResultHi, ResultLo});
        else n_pass++;
        Reset = 1'b0; Start = 1'b0;
        @(posedge Clock); #1;
        n_total++;
        if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL reset_start_ignored busy=%b done=%b required 0 0", Busy, Done);
        else n_pass++;
    endtask

    task automatic test_decode;
        logic [7:0] tbl [12];
        obs_t o;
        exp_t e;
        tbl = '{8'b10_0000_10, 8'b00_0101_11, 8'b01_1111_00, 8'b10_0000_00, 8'b10_0000_01,
                8'b10_0001_01, 8'b10_0010_01, 8'b11_0111_00, 8'b11_1011_10, 8'b10_0000_11,
                8'b10_0100_00, 8'b11_1010_01};
        for (int i = 0; i < 12; i++) begin
            issue(tbl[i][7:6], tbl[i][5:2], tbl[i][1:0], 16'(i * 37), 16'(i + 1), o);
            e = sb_q.pop_front();
            n_total++;
            if (!o.done) $display("FAIL decode_done[%0d] no Done within bound", i); else n_pass++;
            n_total++;
            if (o.op !== e.op || o.ill !== e.ill || o.mc !== e.mc) begin
                $display("FAIL decode_op[%0d] got op=%b ill=%b mc=%b required op=%b ill=%b mc=%b",
                         i, o.op, o.ill, o.mc, e.op, e.ill, e.mc);
            end else n_pass++;
            n_total++;
            if (o.busy !== 0 || o.lo !== e.lo || o.hi !== e.hi || o.dz !== 1'b0) begin
                $display("FAIL decode_hold[%0d] got busy=%0d lo=%h hi=%h dz=%b required 0 %h %h 0",
                         i, o.busy, o.lo, o.hi, o.dz, e.lo, e.hi);
            end else n_pass++;
        end
    endtask

    task automatic test_mul;
        logic [W-1:0] av [4];
        logic [W-1:0] bv [4];
        obs_t o;
        exp_t e;
        av = '{16'hFFFF, 16'h0003, 16'h1234, 16'h0000};
        bv = '{16'hFFFF, 16'h0005, 16'hABCD, 16'h7777};
        for (int i = 0; i < 4; i++) begin
            issue(2'b10, 4'b0011, 2'b00, av[i], bv[i], o);
            e = sb_q.pop_front();
            n_total++;
            if (!o.done || o.busy !== e.busy) $display("FAIL mul_busy[%0d] got done=%b busy=%0d required 1 %0d", i, o.done, o.busy, e.busy);
            else n_pass++;
            n_total++;
            if (o.lo !== e.lo || o.hi !== e.hi) $display("FAIL mul_result[%0d] got %h_%h required %h_%h", i, o.hi, o.lo, e.hi, e.lo);
            else n_pass++;
            n_total++;
            if (o.op !== e.op || o.mc !== 1'b1) $display("FAIL mul_op[%0d] got op=%b mc=%b required %b 1", i, o.op, o.mc, e.op);
            else n_pass++;
        end
    endtask

    task automatic test_div;
        logic [W-1:0] av [5];
        logic [W-1:0] bv [5];
        obs_t o;
        exp_t e;
        av = '{16'd100, 16'd5, 16'd3, 16'hFFFF, 16'hBEEF};
        bv = '{16'd7, 16'd0, 16'd9, 16'd1, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            issue(2'b10, 4'b0011, 2'b01, av[i], bv[i], o);
            e = sb_q.pop_front();
            n_total++;
            if (!o.done || o.busy !== e.busy) $display("FAIL div_busy[%0d] got done=%b busy=%0d required 1 %0d", i, o.done, o.busy, e.busy);
            else n_pass++;
            n_total++;
            if (o.lo !== e.lo || o.hi !== e.hi) $display("FAIL div_result[%0d] got q=%h r=%h required q=%h r=%h", i, o.lo, o.hi, e.lo, e.hi);
            else n_pass++;
            n_total++;
            if (o.dz !== e.dz || o.ill !== 1'b0) $display("FAIL div_flags[%0d] got dz=%b ill=%b required %b 0", i, o.dz, o.ill, e.dz);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort;
        obs_t o;
        exp_t e;
        int busy_cnt;
        int dones;
        ALUOp = 2'b10; OPCODE = 4'b0011; FUNCT = 2'b00; OperandA = 16'hFFFF; OperandB = 16'h0003;
        push_expected(ALUOp, OPCODE, FUNCT, OperandA, OperandB);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (Busy) busy_cnt++;
            if (busy_cnt == 5) break;
            @(posedge Clock); #1;
        end
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        void'(sb_q.pop_back());
        last_lo = '0; last_hi = '0;
        n_total++;
        if ({Operacioni, MultiCycle, Busy, Done, Illegal, DivZero, ResultHi, ResultLo} !== '0) begin
            $display("FAIL abort_outputs got op=%b mc=%b busy=%b done=%b ill=%b dz=%b hi=%h lo=%h required all 0",
                     Operacioni, MultiCycle, Busy, Done, Illegal, DivZero, ResultHi, ResultLo);
        end else n_pass++;
        dones = 0;
        for (int c = 0; c < 20; c++) begin
            if (Done || Busy) dones++;
            @(posedge Clock); #1;
        end
        n_total++;
        if (dones !== 0) $display("FAIL abort_no_done got %0d active cycles required 0", dones);
        else n_pass++;
        issue(2'b11, 4'b1001, 2'b00, 16'h0010, 16'h0020, o);
        e = sb_q.pop_front();
        n_total++;
        if (!o.done || o.op !== e.op || o.lo !== e.lo || o.hi !== e.hi) begin
            $display("FAIL abort_addi got done=%b op=%b lo=%h hi=%h required 1 %b %h %h", o.done, o.op, o.lo, o.hi, e.op, e.lo, e.hi);
        end else n_pass++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int busy_cnt;
        bit changed;
        bit got_done;
        ALUOp = 2'b10; OPCODE = 4'b0011; FUNCT = 2'b00; OperandA = 16'h1234; OperandB = 16'h00AB;
        push_expected(ALUOp, OPCODE, FUNCT, OperandA, OperandB);
        Start = 1'b1;
        @(posedge Clock); #1;
        busy_cnt = 0; changed = 1'b0; got_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (Done) begin got_done = 1'b1; break; end
            if (Busy) busy_cnt++;
            if (busy_cnt == 3 && !changed) begin
                OperandA = 16'h0F0F; OperandB = 16'h0101; changed = 1'b1;
            end
            @(posedge Clock); #1;
        end
        e = sb_q.pop_front();
        n_total++;
        if (!got_done || busy_cnt !== e.busy) $display("FAIL b2b_first_busy got done=%b busy=%0d required 1 %0d", got_done, busy_cnt, e.busy);
        else n_pass++;
        n_total++;
        if (ResultLo !== e.lo || ResultHi !== e.hi) $display("FAIL b2b_first_result got %h_%h required %h_%h", ResultHi, ResultLo, e.hi, e.lo);
        else n_pass++;
        @(posedge Clock); #1;
        n_total++;
        if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL b2b_idle_gap got busy=%b done=%b required 0 0", Busy, Done);
        else n_pass++;
        push_expected(ALUOp, OPCODE, FUNCT, OperandA, OperandB);
        @(posedge Clock); #1;
        Start = 1'b0;
        n_total++;
        if (Busy !== 1'b1) $display("FAIL b2b_second_accept got busy=%b required 1", Busy);
        else n_pass++;
        busy_cnt = 0; got_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (Done) begin got_done = 1'b1; break; end
            if (Busy) busy_cnt++;
            @(posedge Clock); #1;
        end
        e = sb_q.pop_front();
        n_total++;
        if (!got_done || busy_cnt !== e.busy || ResultLo !== e.lo || ResultHi !== e.hi) begin
            $display("FAIL b2b_second_result got done=%b busy=%0d %h_%h required 1 %0d %h_%h",
                     got_done, busy_cnt, ResultHi, ResultLo, e.busy, e.hi, e.lo);
        end else n_pass++;
        @(posedge Clock); #1;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul();
        test_div();
        test_reset_abort();
        test_back_to_back();
        n_total++;
        if (sb_q.size() !== 0) $display("FAIL scoreboard_empty got %0d entries required 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
